seg7_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the FPGA test board; replaces the fixed single-digit anode tie-off.
- Holds four digit patterns and drives one digit per time slot, with a blanking gap before each slot to suppress ghosting.
- Digit patterns are written into a shadow bank and take effect together, at a frame boundary, on commit. This gives tear-free updates from the user design or board glue.

---
 rtl/seg7_scan_ctrl.sv | 98 +++++++++
 tb/tb_seg7_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit common-anode 7-segment scan controller
// Shadow/active digit banks with frame-aligned commit and per-slot blanking.
module seg7_scan_ctrl #(
  parameter int SLOT_CYCLES  = 12500,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic [3:0] digit_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick,
  output logic       commit_pend
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  typedef enum logic {BLANK, ON} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [7:0]    shadow [4];
  logic [7:0]    active [4];

  logic slot_end;
  logic boundary;

  assign slot_end = (cnt == CW'(SLOT_CYCLES - 1));
  assign boundary = ena && slot_end && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= 2'd0;
      an          <= 4'hF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_tick  <= 1'b0;
      commit_pend <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 8'h00;
        active[i] <= 8'h00;
      end
    end else begin
      if (wr_en)
        shadow[wr_addr] <= wr_data;

      // A commit landing in the boundary cycle itself survives as the next pending request.
      if (boundary && commit_pend) begin
        for (int i = 0; i < 4; i++)
          active[i] <= shadow[i];
        commit_pend <= commit;
      end else begin
        commit_pend <= commit_pend | commit;
      end

      if (!ena) begin
        state      <= BLANK;
        cnt        <= '0;
        idx        <= 2'd0;
        an         <= 4'hF;
        seg        <= 7'h7F;
        dp         <= 1'b1;
        frame_tick <= 1'b0;
      end else begin
        frame_tick <= boundary;

        if (state == ON && digit_en[idx]) begin
          an        <= ~(4'b0001 << idx);
          {dp, seg} <= ~active[idx];
        end else begin
          an  <= 4'hF;
          seg <= 7'h7F;
          dp  <= 1'b1;
        end

        if (slot_end) begin
          cnt   <= '0;
          state <= BLANK;
          idx   <= idx + 2'd1;
        end else begin
          cnt <= cnt + CW'(1);
          if (state == BLANK && cnt == CW'(BLANK_CYCLES - 1))
            state <= ON;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
// Reference model tracks frame position and digit banks with plain arithmetic.
module tb_seg7_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic [3:0] digit_en;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;
  logic       commit_pend;

  seg7_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .digit_en(digit_en), .seg(seg), .dp(dp),
    .an(an), .frame_tick(frame_tick), .commit_pend(commit_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_shadow [4];
  logic [7:0] m_active [4];
  int         m_pos;
  logic       m_pend;
  logic [3:0] e_an;
  logic [7:0] e_segdp;
  logic       e_tick;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pos  = 0;
    m_pend = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".an"}, {4'h0, an}, {4'h0, e_an});
    check({tag, ".segdp"}, {dp, seg}, e_segdp);
    check({tag, ".tick"}, {7'h0, frame_tick}, {7'h0, e_tick});
    check({tag, ".pend"}, {7'h0, commit_pend}, {7'h0, m_pend});
  endtask

  // One clock edge: model consumes the inputs present at the edge, then outputs are compared.
  task automatic step(input string tag);
    int         slot;
    int         off;
    logic       lit;
    logic       bnd;
    logic [3:0] onehot;
    @(posedge clk);
    slot = m_pos / SLOT;
    off  = m_pos % SLOT;
    lit  = ena && (off >= BLANK) && digit_en[slot];
    onehot  = 4'b0001 << slot;
    e_an    = lit ? ~onehot : 4'hF;
    e_segdp = lit ? ~m_active[slot] : 8'hFF;
    bnd     = ena && (m_pos == FRAME - 1);
    e_tick  = bnd;
    if (bnd && m_pend) begin
      for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
      m_pend = commit;
    end else begin
      m_pend = m_pend | commit;
    end
    if (wr_en) m_shadow[wr_addr] = wr_data;
    m_pos = ena ? (m_pos + 1) % FRAME : 0;
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic write(input logic [1:0] a, input logic [7:0] d, input logic c);
    wr_en = 1'b1; wr_addr = a; wr_data = d; commit = c;
    step("write");
    wr_en = 1'b0; commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
    commit = 1'b0; digit_en = 4'hF;
    model_reset();
    #12;
    rst_n = 1'b1;
    e_an = 4'hF; e_segdp = 8'hFF; e_tick = 1'b0;
    check_outputs("reset");

    run("blank_frames", 70);

    run("pre_w1", 5);
    write(2'd1, 8'h86, 1'b0);
    commit = 1'b1; step("commit1"); commit = 1'b0;
    run("after_commit1", 70);

    write(2'd0, 8'h3F, 1'b0);
    run("shadow_only", 3 * FRAME);
    commit = 1'b1; step("commit0"); commit = 1'b0;
    run("after_commit0", 40);

    write(2'd2, 8'h5B, 1'b0);
    begin
      int k = 0;
      while (m_pos != FRAME - 1 && k < 2 * FRAME) begin step("seek_bnd"); k++; end
      check("seek_bnd_bound", {7'h0, (m_pos == FRAME - 1)}, 8'h01);
    end
    commit = 1'b1; step("commit_at_bnd"); commit = 1'b0;
    run("deferred", 70);

    for (int i = 0; i < 4; i++) write(2'(i), 8'h7F, 1'b0);
    commit = 1'b1; step("commit_all"); commit = 1'b0;
    run("pre_en", 40);
    digit_en = 4'b0101;
    run("digit_en", 70);
    digit_en = 4'hF;

    begin
      int k = 0;
      while (m_pos != 2 * SLOT + 4 && k < 2 * FRAME) begin step("seek_slot2"); k++; end
      check("seek_slot2_bound", {7'h0, (m_pos == 2 * SLOT + 4)}, 8'h01);
    end
    write(2'd3, 8'h06, 1'b1);
    ena = 1'b0;
    run("ena_low", 5);
    ena = 1'b1;
    run("ena_restart", 70);

    for (int i = 0; i < 700; i++) begin
      ena      = ($urandom_range(0, 99) != 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 8'($urandom);
      commit   = ($urandom_range(0, 19) == 0);
      digit_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step("random");
    end
    ena = 1'b1; wr_en = 1'b0; commit = 1'b0; digit_en = 4'hF;

    write(2'd0, 8'h3F, 1'b1);
    begin
      int k = 0;
      while (e_an == 4'hF && k < 2 * FRAME) begin step("seek_lit"); k++; end
      check("seek_lit_bound", {4'h0, e_an}, {4'h0, (e_an == 4'hF) ? 4'h0 : e_an});
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    e_an = 4'hF; e_segdp = 8'hFF; e_tick = 1'b0;
    check_outputs("async_rst");
    #2;
    rst_n = 1'b1;
    run("post_rst", 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
